// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward receive frame FIFO behind the MAC receiver: only frames that end cleanly
// with tlast and tuser low become visible on the AXIS master side; bad or oversized frames are rolled back.
module eth_rx_frame_fifo #(
    parameter int C_ADDR_WIDTH = 11,
    parameter int C_CNT_WIDTH  = 16
) (
    input  logic                   rx_mac_aclk,
    input  logic                   rx_mac_reset,
    input  logic [7:0]             s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tuser,
    output logic [7:0]             m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [C_CNT_WIDTH-1:0] good_frame_cnt,
    output logic [C_CNT_WIDTH-1:0] bad_frame_cnt,
    output logic [C_CNT_WIDTH-1:0] ovf_frame_cnt
);

    localparam int DEPTH = 2 ** C_ADDR_WIDTH;
    localparam int PW    = C_ADDR_WIDTH + 1;
    localparam logic [PW-1:0]          PTR_ONE   = PW'(1);
    localparam logic [PW-1:0]          DEPTH_PTR = PW'(DEPTH);
    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE   = C_CNT_WIDTH'(1);

    // Counter select bits for cnt_inc
    localparam int CNT_GOOD = 0;
    localparam int CNT_BAD  = 1;
    localparam int CNT_OVF  = 2;

    typedef enum logic {
        WR_STORE,
        WR_DISCARD
    } wr_state_t;

    wr_state_t     state_reg;
    wr_state_t     state_next;
    logic [PW-1:0] wr_addr_reg;
    logic [PW-1:0] wr_addr_next;
    logic [PW-1:0] wr_commit_reg;
    logic [PW-1:0] wr_commit_next;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] fill;
    logic          writable;
    logic          mem_we;
    logic          avail;
    logic          rd_en;
    logic [2:0]    cnt_inc;

    logic [8:0] mem [DEPTH];

    // Pointers carry one extra wrap bit, so a completely full buffer has fill == DEPTH.
    assign fill     = wr_addr_reg - rd_ptr_reg;
    assign writable = (fill < DEPTH_PTR);

    always_comb begin
        state_next     = state_reg;
        wr_addr_next   = wr_addr_reg;
        wr_commit_next = wr_commit_reg;
        mem_we         = 1'b0;
        cnt_inc        = '0;
        if (s_axis_tvalid) begin
            case (state_reg)
                WR_STORE: begin
                    if (writable) begin
                        mem_we       = 1'b1;
                        wr_addr_next = wr_addr_reg + PTR_ONE;
                        if (s_axis_tlast) begin
                            if (s_axis_tuser) begin
                                wr_addr_next      = wr_commit_reg;
                                cnt_inc[CNT_BAD]  = 1'b1;
                            end else begin
                                wr_commit_next    = wr_addr_reg + PTR_ONE;
                                cnt_inc[CNT_GOOD] = 1'b1;
                            end
                        end
                    end else if (s_axis_tlast) begin
                        // Overflow on the final beat: tuser is irrelevant, it counts as overflow.
                        wr_addr_next     = wr_commit_reg;
                        cnt_inc[CNT_OVF] = 1'b1;
                    end else begin
                        state_next = WR_DISCARD;
                    end
                end
                WR_DISCARD: begin
                    if (s_axis_tlast) begin
                        wr_addr_next     = wr_commit_reg;
                        cnt_inc[CNT_OVF] = 1'b1;
                        state_next       = WR_STORE;
                    end
                end
                default: begin
                    state_next = WR_STORE;
                end
            endcase
        end
    end

    always_ff @(posedge rx_mac_aclk or posedge rx_mac_reset) begin
        if (rx_mac_reset) begin
            state_reg     <= WR_STORE;
            wr_addr_reg   <= '0;
            wr_commit_reg <= '0;
        end else begin
            state_reg     <= state_next;
            wr_addr_reg   <= wr_addr_next;
            wr_commit_reg <= wr_commit_next;
        end
    end

    // RAM has no reset; stale contents are never read because rd_ptr only chases wr_commit.
    always_ff @(posedge rx_mac_aclk) begin
        if (mem_we) begin
            mem[wr_addr_reg[C_ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    assign avail = (rd_ptr_reg != wr_commit_reg);
    assign rd_en = avail && (!m_axis_tvalid || m_axis_tready);

    // The output register doubles as the RAM read register, giving one byte per cycle.
    always_ff @(posedge rx_mac_aclk or posedge rx_mac_reset) begin
        if (rx_mac_reset) begin
            rd_ptr_reg    <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (rd_en) begin
            {m_axis_tlast, m_axis_tdata} <= mem[rd_ptr_reg[C_ADDR_WIDTH-1:0]];
            rd_ptr_reg    <= rd_ptr_reg + PTR_ONE;
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [C_CNT_WIDTH-1:0] cnt_reg;
            always_ff @(posedge rx_mac_aclk or posedge rx_mac_reset) begin
                if (rx_mac_reset) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                end
            end
        end
    endgenerate

    assign good_frame_cnt = g_cnt[CNT_GOOD].cnt_reg;
    assign bad_frame_cnt  = g_cnt[CNT_BAD].cnt_reg;
    assign ovf_frame_cnt  = g_cnt[CNT_OVF].cnt_reg;

endmodule
